// File: rtl/tinyalu_arbiter_if.sv
// Requester-side bus of the TinyALU arbiter: per-requester request slices plus the shared response.
interface tinyalu_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [8*N_REQ-1:0] req_A;
  logic [8*N_REQ-1:0] req_B;
  logic [3*N_REQ-1:0] req_op;
  logic [N_REQ-1:0]   rsp_valid;
  logic [15:0]        rsp_result;
  logic               rsp_err;

  modport slave (
    input  req_valid, req_A, req_B, req_op,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );

  modport master (
    output req_valid, req_A, req_B, req_op,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );
endinterface

// File: rtl/tinyalu_arbiter.sv
// Round-robin arbiter sharing one TinyALU between N_REQ requesters; non-ALU opcodes answered locally.
// state | meaning
// IDLE  | grant computed combinationally, waiting for an accept
// WAIT  | ALU op in flight, start held high, watchdog running
// RESP  | one-cycle response strobe to the granted requester
module tinyalu_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  tinyalu_arbiter_if.slave    bus,
  output logic                busy,
  output logic [7:0]          alu_A,
  output logic [7:0]          alu_B,
  output logic [2:0]          alu_op,
  output logic                alu_start,
  input  logic                alu_done,
  input  logic [15:0]         alu_result
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, idx_q, grant_idx;
  logic [N_REQ-1:0] grant;
  logic             grant_found;
  logic [WD_W-1:0]  wdog;
  logic [7:0]       a_q, b_q, sel_A, sel_B;
  logic [2:0]       op_q, sel_op;
  logic [15:0]      result_q;
  logic             err_q;
  logic             accept, accept_alu, done_hit, timeout_hit;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b010) || (op == 3'b011) || (op == 3'b100);
  endfunction

  // Two passes: first from rr_ptr upward, then wrap around from index 0.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_found && bus.req_valid[i] && (i >= int'(rr_ptr))) begin
        grant_found = 1'b1;
        grant[i]    = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_found && bus.req_valid[i]) begin
        grant_found = 1'b1;
        grant[i]    = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sel_A  = '0;
    sel_B  = '0;
    sel_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_A  = bus.req_A[8*i +: 8];
        sel_B  = bus.req_B[8*i +: 8];
        sel_op = bus.req_op[3*i +: 3];
      end
    end
  end

  assign accept      = (state == IDLE) && grant_found;
  assign accept_alu  = accept && is_alu_op(sel_op);
  assign done_hit    = (state == WAIT) && alu_done;
  assign timeout_hit = (state == WAIT) && !alu_done && (wdog == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    alu_start     = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE: begin
        bus.req_ready = grant;
        if (accept) state_nxt = accept_alu ? WAIT : RESP;
      end
      WAIT: begin
        alu_start = 1'b1;
        if (done_hit || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        for (int i = 0; i < N_REQ; i++) bus.rsp_valid[i] = (idx_q == IDX_W'(i));
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      idx_q    <= '0;
      wdog     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx_q  <= grant_idx;
        rr_ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        wdog   <= '0;
        // ALU-facing operands only move for ops the ALU actually executes.
        if (accept_alu) begin
          a_q  <= sel_A;
          b_q  <= sel_B;
          op_q <= sel_op;
        end else begin
          result_q <= 16'h0000;
          err_q    <= 1'b0;
        end
      end
      if (done_hit) begin
        result_q <= alu_result;
        err_q    <= 1'b0;
      end else if (timeout_hit) begin
        result_q <= 16'hDEAD;
        err_q    <= 1'b1;
      end else if (state == WAIT) begin
        wdog <= wdog + 1'b1;
      end
    end
  end

  assign alu_A          = a_q;
  assign alu_B          = b_q;
  assign alu_op         = op_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_err    = err_q;

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Directed and random checks of the TinyALU round-robin arbiter against a small behavioural ALU.
module tb_tinyalu_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        busy, alu_start, alu_done;
  logic [7:0]  alu_A, alu_B;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rsp_count = 0;

  int alu_lat = 1;
  bit alu_hang = 1'b0;
  bit alu_force = 1'b0;
  int alu_cnt = 0;

  tinyalu_arbiter_if #(.N_REQ(4)) bus ();

  tinyalu_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (|bus.rsp_valid) rsp_count++;

  function automatic logic [15:0] ref_calc(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'b001:  return 16'(a) + 16'(b);
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  // ALU model: raises done on the alu_lat-th start cycle, computed from the operands it is shown.
  initial begin
    alu_done   = 1'b0;
    alu_result = '0;
  end
  always @(negedge clk) begin
    if (alu_start) alu_cnt++;
    else alu_cnt = 0;
    alu_done   = alu_force | (alu_start && !alu_hang && alu_cnt == alu_lat);
    alu_result = alu_done ? ref_calc(alu_A, alu_B, alu_op) : 16'h0000;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int r, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       output int lat_cyc, output logic [15:0] res, output logic er,
                       output logic [3:0] rv, output int starts);
    int t_acc;
    bit ok;
    t_acc = 0; ok = 1'b0; starts = 0; res = '0; er = 1'b0; rv = '0;
    bus.req_A[8*r +: 8]  = a;
    bus.req_B[8*r +: 8]  = b;
    bus.req_op[3*r +: 3] = op;
    bus.req_valid[r]     = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      #1;
      if (bus.req_ready[r]) begin
        ok = 1'b1;
        t_acc = cyc;
      end
      clk1();
    end
    bus.req_valid[r] = 1'b0;
    chk("accept_seen", 32'(ok), 32'd1);
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      if (alu_start) starts++;
      if (|bus.rsp_valid) begin
        ok = 1'b1;
        res = bus.rsp_result;
        er = bus.rsp_err;
        rv = bus.rsp_valid;
      end else begin
        clk1();
      end
    end
    chk("rsp_seen", 32'(ok), 32'd1);
    lat_cyc = cyc - t_acc;
  endtask

  initial begin
    int lat_cyc, starts, c0;
    logic [15:0] res;
    logic er;
    logic [3:0] rv, e;
    logic [7:0] a, b;
    logic [2:0] op;
    int r;
    bit got;

    reset_n = 1'b0;
    bus.req_valid = '0;
    bus.req_A = '0;
    bus.req_B = '0;
    bus.req_op = '0;
    clk1();
    clk1();
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_alu_A", 32'(alu_A), 32'd0);
    chk("rst_alu_B", 32'(alu_B), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    reset_n = 1'b1;
    clk1();

    // Basic add from requester 0, done on the 3rd WAIT cycle.
    alu_lat = 3;
    do_op(0, 8'h12, 8'h34, 3'b001, lat_cyc, res, er, rv, starts);
    chk("add_result", 32'(res), 32'h0046);
    chk("add_err", 32'(er), 32'd0);
    chk("add_rv", 32'(rv), 32'b0001);
    chk("add_latency", 32'(lat_cyc), 32'd4);
    chk("add_starts", 32'(starts), 32'd3);
    chk("add_alu_A", 32'(alu_A), 32'h12);
    chk("add_alu_B", 32'(alu_B), 32'h34);
    chk("add_alu_op", 32'(alu_op), 32'b001);
    clk1();
    chk("add_rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
    chk("add_idle", 32'(busy), 32'd0);

    // alu_done outside WAIT must be ignored.
    c0 = rsp_count;
    alu_force = 1'b1;
    clk1(); clk1(); clk1();
    chk("spurious_done_busy", 32'(busy), 32'd0);
    chk("spurious_done_rsp", 32'(rsp_count), 32'(c0));
    alu_force = 1'b0;
    clk1();

    // All four hold mul FF*FF from reset: grants 0,1,2,3,0.
    reset_n = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_A = {4{8'hFF}};
    bus.req_B = {4{8'hFF}};
    bus.req_op = {4{3'b100}};
    alu_lat = 2;
    clk1();
    clk1();
    reset_n = 1'b1;
    #1;
    chk("rr_first_ready", 32'(bus.req_ready), 32'b0001);
    for (int k = 0; k < 5; k++) begin
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
        if (|bus.rsp_valid) got = 1'b1;
        else clk1();
      end
      e = 4'b0001 << (k % 4);
      chk("rr_rsp_seen", 32'(got), 32'd1);
      chk("rr_order", 32'(bus.rsp_valid), 32'(e));
      chk("rr_result", 32'(bus.rsp_result), 32'hFE01);
      chk("rr_start_low_in_resp", 32'(alu_start), 32'd0);
      if (k == 4) bus.req_valid = '0;
      clk1();
      chk("rr_idle_gap", 32'(alu_start), 32'd0);
    end
    clk1();
    chk("rr_drained", 32'(busy), 32'd0);

    // Local ops from requester 2.
    for (int k = 0; k < 3; k++) begin
      op = (k == 0) ? 3'b000 : (k == 1) ? 3'b110 : 3'b111;
      do_op(2, 8'hA5, 8'h5A, op, lat_cyc, res, er, rv, starts);
      chk("local_result", 32'(res), 32'h0000);
      chk("local_latency", 32'(lat_cyc), 32'd1);
      chk("local_starts", 32'(starts), 32'd0);
      chk("local_rv", 32'(rv), 32'b0100);
      clk1();
    end

    // Timeout, then a normal op, then done on the final WAIT cycle.
    alu_hang = 1'b1;
    do_op(1, 8'h01, 8'h02, 3'b001, lat_cyc, res, er, rv, starts);
    chk("to_result", 32'(res), 32'hDEAD);
    chk("to_err", 32'(er), 32'd1);
    chk("to_latency", 32'(lat_cyc), 32'd17);
    chk("to_starts", 32'(starts), 32'd16);
    chk("to_start_low", 32'(alu_start), 32'd0);
    chk("to_rv", 32'(rv), 32'b0010);
    clk1();
    alu_hang = 1'b0;
    alu_lat = 1;
    do_op(1, 8'h0F, 8'hF0, 3'b011, lat_cyc, res, er, rv, starts);
    chk("after_to_result", 32'(res), 32'h00FF);
    chk("after_to_err", 32'(er), 32'd0);
    chk("after_to_latency", 32'(lat_cyc), 32'd2);
    clk1();
    alu_lat = 16;
    do_op(3, 8'h03, 8'h05, 3'b010, lat_cyc, res, er, rv, starts);
    chk("last_wait_result", 32'(res), 32'h0001);
    chk("last_wait_err", 32'(er), 32'd0);
    chk("last_wait_latency", 32'(lat_cyc), 32'd17);
    chk("last_wait_rv", 32'(rv), 32'b1000);
    clk1();

    // Reset during WAIT of an xor from requester 1 (rr_ptr would otherwise be 2).
    alu_hang = 1'b1;
    bus.req_A[15:8] = 8'h5A;
    bus.req_B[15:8] = 8'h0F;
    bus.req_op[5:3] = 3'b011;
    bus.req_valid = 4'b0010;
    #1;
    chk("mid_rst_ready", 32'(bus.req_ready), 32'b0010);
    clk1();
    bus.req_valid = '0;
    chk("mid_rst_wait_start", 32'(alu_start), 32'd1);
    clk1();
    clk1();
    c0 = rsp_count;
    reset_n = 1'b0;
    clk1();
    chk("mid_rst_start_low", 32'(alu_start), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    reset_n = 1'b1;
    alu_hang = 1'b0;
    alu_lat = 1;
    bus.req_A = {8'h11, 8'h00, 8'h00, 8'h22};
    bus.req_B = {8'h01, 8'h00, 8'h00, 8'h03};
    bus.req_op = {3'b001, 3'b000, 3'b000, 3'b001};
    bus.req_valid = 4'b1001;
    #1;
    chk("post_rst_grant", 32'(bus.req_ready), 32'b0001);
    clk1();
    bus.req_valid = '0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      if (|bus.rsp_valid) got = 1'b1;
      else clk1();
    end
    chk("post_rst_rsp_seen", 32'(got), 32'd1);
    chk("post_rst_rv", 32'(bus.rsp_valid), 32'b0001);
    chk("post_rst_result", 32'(bus.rsp_result), 32'h0025);
    clk1();
    chk("post_rst_single_rsp", 32'(rsp_count), 32'(c0 + 1));

    // Random ops, one requester at a time, corner operands included.
    c0 = rsp_count;
    for (int k = 0; k < 1000; k++) begin
      r = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: a = 8'h00;
        1: a = 8'hFF;
        default: a = 8'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 3))
        0: b = 8'h00;
        1: b = 8'hFF;
        default: b = 8'($urandom_range(0, 255));
      endcase
      op = 3'($urandom_range(0, 7));
      alu_lat = $urandom_range(1, 4);
      do_op(r, a, b, op, lat_cyc, res, er, rv, starts);
      e = 4'b0001 << r;
      chk("rand_result", 32'(res), 32'(ref_calc(a, b, op)));
      chk("rand_rv", 32'(rv), 32'(e));
      chk("rand_err", 32'(er), 32'd0);
      chk("rand_latency", 32'(lat_cyc), (op >= 3'b001 && op <= 3'b100) ? 32'(alu_lat + 1) : 32'd1);
      clk1();
    end
    chk("rand_rsp_count", 32'(rsp_count - c0), 32'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
